// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed N-digit seven-segment driver with shadowed data, PWM dimming and dead time
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out
);
    localparam int   PW  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int   IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [3:0]              pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
    logic [NUM_DIGITS-1:0]   sblank_q, sblank_d;
    logic                    pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;

    logic       tick, wrap, cap, lit, sup;
    logic [3:0] nib;
    logic [6:0] dec;

    // Scan timing, PWM counter and frame-aligned shadow capture
    always_comb begin
        tick     = presc_q == PW'(SCAN_DIV - 1);
        wrap     = tick && idx_q == IW'(NUM_DIGITS - 1);
        cap      = wrap && (pend_q || load);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        pwm_d    = pwm_q + 4'd1;
        val_d    = cap ? value : val_q;
        sdp_d    = cap ? dp : sdp_q;
        sblank_d = cap ? blank : sblank_q;
        pend_d   = wrap ? 1'b0 : (pend_q || load);
    end

    // Hex nibble to active-high {g..a} segment pattern
    always_comb begin
        nib = val_q[{idx_q, 2'b00} +: 4];
        dec = 7'h00;
        case (nib)
            4'h0: dec = 7'h3F;
            4'h1: dec = 7'h06;
            4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;
            4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D;
            4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;
            4'h9: dec = 7'h6F;
            4'hA: dec = 7'h77;
            4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;
            4'hD: dec = 7'h5E;
            4'hE: dec = 7'h79;
            4'hF: dec = 7'h71;
            default: dec = 7'h00;
        endcase
    end

    // Lit rule, leading-zero suppression and pin polarity for the next registered outputs
    always_comb begin
        lit      = presc_q >= PW'(BLANK_CYCLES) && brightness > pwm_q && !sblank_q[idx_q];
        sup      = lz_en && idx_q != '0 && (val_q >> {idx_q, 2'b00}) == '0;
        an_d     = (lit ? NUM_DIGITS'(1) << idx_q : '0) ^ {NUM_DIGITS{INV}};
        seg_d    = (lit && !sup ? dec : 7'h00) ^ {7{INV}};
        dp_out_d = (lit && sdp_q[idx_q]) ^ INV;
    end

    // State and output registers; reset blanks the pins and drops any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            pwm_q    <= '0;
            val_q    <= '0;
            sdp_q    <= '0;
            sblank_q <= '0;
            pend_q   <= 1'b0;
            an_q     <= {NUM_DIGITS{INV}};
            seg_q    <= {7{INV}};
            dp_out_q <= INV;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            pwm_q    <= pwm_d;
            val_q    <= val_d;
            sdp_q    <= sdp_d;
            sblank_q <= sblank_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp_out = dp_out_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed and random checks of the scanner against a time-based reference model
module tb_seven_segment_scanner;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out;

    int          tests = 0;
    int          fails = 0;
    int          t = 0;
    logic [15:0] sval = '0;
    logic [3:0]  sdp = '0;
    logic [3:0]  sblank = '0;
    bit          pend = 1'b0;
    logic [6:0]  tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank(blank), .load(load),
        .lz_en(lz_en), .brightness(brightness), .an(an), .seg(seg), .dp_out(dp_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp_out), 32'h1);
    endtask

    // One clock: the pins after the edge reflect the scan position t since reset release
    task automatic step();
        int p = t % SD;
        int i = (t / SD) % N;
        int w = t % 16;
        bit lit, sup, wrap;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        lit  = p >= BC && int'(brightness) > w && !sblank[i];
        sup  = lz_en && i > 0 && (sval >> (4 * i)) == 16'h0;
        ea   = lit ? ~(4'b1 << i) : 4'hF;
        es   = (lit && !sup) ? ~tab[sval[4*i +: 4]] : 7'h7F;
        ed   = !(lit && sdp[i]);
        wrap = p == SD - 1 && i == N - 1;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp_out", 32'(dp_out), 32'(ed));
        if (wrap && (pend || load)) begin
            sval   = value;
            sdp    = dp;
            sblank = blank;
            pend   = 1'b0;
        end else if (load) begin
            pend = 1'b1;
        end
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_off("reset");
        rst_n = 1'b1;
        run(32);
        while (t % (SD * N) != SD * N - 1) step();
        pulse_load(16'h12AF);
        run(34);
        while (t % (SD * N) != 0) step();
        pulse_load(16'h0000);
        while (t % (SD * N) != 0) step();
        while ((t / SD) % N != 1) step();
        pulse_load(16'h5555);
        run(36);
        lz_en = 1'b1;
        pulse_load(16'h0070);
        run(40);
        pulse_load(16'h0000);
        run(40);
        lz_en = 1'b0;
        brightness = 4'd0;
        pulse_load(16'h9876);
        run(36);
        brightness = 4'd8;
        dp = 4'b0100;
        pulse_load(16'h3C4D);
        run(48);
        repeat (400) begin
            load = $urandom_range(0, 5) == 0;
            if (load) value = 16'($urandom);
            dp = 4'($urandom);
            blank = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 23) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 23) == 0) lz_en = 1'($urandom);
            step();
        end
        load = 1'b0;
        blank = 4'h0;
        dp = 4'hF;
        brightness = 4'd15;
        pulse_load(16'hBEEF);
        run(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_rst");
        t = 0;
        sval = '0;
        sdp = '0;
        sblank = '0;
        pend = 1'b0;
        @(posedge clk);
        #1;
        check_off("rst_hold");
        rst_n = 1'b1;
        run(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
